// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register peripheral.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a history
// flop that turns transitions into single-clk rise/fall pulses.
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   hist_q, hist_d;

  // Advance the raw pin through the chain; the history flop keeps the previous synced level.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], din};
    hist_d  = chain_q[SYNC_STAGES-1];
  end

  // Chain and history reset to the pin's idle level so no edge fires out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {SYNC_STAGES{RST_VAL}};
      hist_q  <= RST_VAL;
    end else begin
      chain_q <= chain_d;
      hist_q  <= hist_d;
    end
  end

  assign sync_out = chain_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~hist_q;
  assign fall     = ~sync_out & hist_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 target writing five 8-bit control registers from 16-bit frames
// (bit15 = R/W, bits14:8 = address, bits7:0 = data). Optional register
// readback on cipo_out is enabled by defining SPI_READBACK_EN.
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              copi_in,
  input  logic              ncs_in,
  output logic              cipo_out,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle
);

  localparam int                CNT_W      = 5;
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_OVER   = CNT_W'(FRAME_BITS + 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR_L = ADDR_W'(MAX_ADDR);

  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;
  logic ncs_s, ncs_rise, ncs_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk_in),
    .sync_out(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi_in),
    .sync_out(copi_s), .rise(copi_rise), .fall(copi_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs_in),
    .sync_out(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d, shift_nx;
  logic [DATA_W-1:0]       out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic [DATA_W-1:0]       pwm_lo_q, pwm_lo_d, pwm_hi_q, pwm_hi_d;
  logic [DATA_W-1:0]       duty_q, duty_d;

  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;

  // Frame FSM: ncs edges delimit frames; sclk edges only count inside SHIFT,
  // and an ncs rise wins over a coincident sclk rise.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    shift_nx  = {shift_q[FRAME_BITS-2:0], copi_s};
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise) begin
          shift_d = shift_nx;
          if (bit_cnt_q != CNT_OVER) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        // A new frame starting while committing goes straight back to SHIFT
        // so its falling edge is not lost; the write still completes this cycle.
        if (ncs_fall) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_addr = shift_q[FRAME_BITS-2 -: ADDR_W];
  assign wr_data = shift_q[DATA_W-1:0];
  assign wr_en   = (state_q == ST_COMMIT) && (bit_cnt_q == CNT_FULL) &&
                   shift_q[FRAME_BITS-1] && (wr_addr <= MAX_ADDR_L);

  // Register file update: only exact 16-bit write frames to a valid address land.
  always_comb begin
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    pwm_lo_d = pwm_lo_q;
    pwm_hi_d = pwm_hi_q;
    duty_d   = duty_q;
    if (wr_en) begin
      case (wr_addr)
        ADDR_EN_OUT_LO: out_lo_d = wr_data;
        ADDR_EN_OUT_HI: out_hi_d = wr_data;
        ADDR_EN_PWM_LO: pwm_lo_d = wr_data;
        ADDR_EN_PWM_HI: pwm_hi_d = wr_data;
        ADDR_PWM_DUTY:  duty_d   = wr_data;
        default: ;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_addr = shift_nx[ADDR_W-1:0];

  // Readback mux keyed on the address as it completes on the 8th bit.
  always_comb begin
    rd_data = '0;
    if (rd_addr <= MAX_ADDR_L) begin
      case (rd_addr)
        ADDR_EN_OUT_LO: rd_data = out_lo_q;
        ADDR_EN_OUT_HI: rd_data = out_hi_q;
        ADDR_EN_PWM_LO: rd_data = pwm_lo_q;
        ADDR_EN_PWM_HI: rd_data = pwm_hi_q;
        ADDR_PWM_DUTY:  rd_data = duty_q;
        default:        rd_data = '0;
      endcase
    end
  end

  // Tx shifter: load on the 8th rising edge of a read frame, then advance on
  // falling edges from bit 9 on so each bit is stable before the controller samples.
  always_comb begin
    tx_d = tx_q;
    if (state_q != ST_SHIFT || state_d != ST_SHIFT) begin
      tx_d = '0;
    end else if (sclk_rise && bit_cnt_q == CNT_W'(DATA_W - 1) && !shift_nx[DATA_W-1]) begin
      tx_d = rd_data;
    end else if (sclk_fall && bit_cnt_q >= CNT_W'(DATA_W + 1)) begin
      tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo_out = tx_q[DATA_W-1];

  logic unused_sigs;
  assign unused_sigs = ^{sclk_s, ncs_s, copi_rise, copi_fall};
`else
  assign cipo_out = 1'b0;

  logic unused_sigs;
  assign unused_sigs = ^{sclk_s, ncs_s, copi_rise, copi_fall, sclk_fall};
`endif

  // State, frame datapath and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      out_lo_q  <= '0;
      out_hi_q  <= '0;
      pwm_lo_q  <= '0;
      pwm_hi_q  <= '0;
      duty_q    <= '0;
`ifdef SPI_READBACK_EN
      tx_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      out_lo_q  <= out_lo_d;
      out_hi_q  <= out_hi_d;
      pwm_lo_q  <= pwm_lo_d;
      pwm_hi_q  <= pwm_hi_d;
      duty_q    <= duty_d;
`ifdef SPI_READBACK_EN
      tx_q      <= tx_d;
`endif
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;

endmodule
